// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
package imem_loader_pkg;

  // Loader sequencing: header bytes, data bytes, one-cycle BRAM write, terminal states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  localparam int          LEN_BYTES  = 2;
  localparam int          WORD_BYTES = 4;
  localparam logic [3:0]  WE_ALL     = 4'hF;

endpackage

// File: rtl/imem_loader_byte_to_word.sv
// Little-endian byte packer: byte 0 lands in word[7:0]; word_valid marks the
// accept cycle of the fourth byte so the caller can schedule the write.
module byte_to_word
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0] lane;

  // Last lane of the word is being filled this cycle.
  assign word_valid = byte_valid && (lane == 2'(WORD_BYTES - 1));

  // Lane counter and assembly register; lane wraps naturally after the 4th byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane <= 2'd0;
      word <= 32'd0;
    end else if (clr) begin
      lane <= 2'd0;
    end else if (byte_valid) begin
      word[{lane, 3'b000} +: 8] <= byte_data;
      lane                      <= lane + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Program loader: parses a length-prefixed byte stream and writes 32-bit words
// into the instruction-memory BRAM, holding the core out of run until done.
//
// Stream handshake: a byte is transferred on a rising edge where s_valid and
// s_ready are both high; s_ready depends only on registered state, and the
// source must hold s_data stable while s_valid is high and s_ready is low.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 1024,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              mem_ena,
  output logic [3:0]        mem_wea,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       words_loaded,
  output state_t            dbg_state
);

  localparam logic [16:0]       DEPTH_W = 17'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_W  = ADDR_W'(BASE_ADDR);

  state_t      state;
  logic [7:0]  count_hi;
  logic [15:0] remaining;
  logic [15:0] full_count;
  logic        hs;
  logic        word_valid;
  logic [31:0] word;

  assign hs         = s_valid && s_ready;
  assign full_count = {count_hi, s_data};

  // All outputs decode from the registered state; no path from s_valid to s_ready.
  assign s_ready   = (state == ST_LEN_HI) || (state == ST_LEN_LO) || (state == ST_DATA);
  assign busy      = s_ready || (state == ST_WRITE);
  assign done      = (state == ST_DONE);
  assign err       = (state == ST_ERR);
  assign mem_ena   = (state == ST_WRITE);
  assign mem_wea   = (state == ST_WRITE) ? WE_ALL : 4'h0;
  assign mem_din   = word;
  assign dbg_state = state;

  byte_to_word u_b2w (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (state == ST_LEN_LO),
    .byte_valid (hs && (state == ST_DATA)),
    .byte_data  (s_data),
    .word       (word),
    .word_valid (word_valid)
  );

  // Load sequencer with address, progress and remaining-word counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      count_hi     <= 8'd0;
      remaining    <= 16'd0;
      mem_addr     <= BASE_W;
      words_loaded <= 16'd0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state        <= ST_LEN_HI;
            words_loaded <= 16'd0;
            mem_addr     <= BASE_W;
          end
        end
        ST_LEN_HI: begin
          if (hs) begin
            count_hi <= s_data;
            state    <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (hs) begin
            if (full_count == 16'd0) begin
              state <= ST_DONE;
            end else if ({1'b0, full_count} > DEPTH_W) begin
              state <= ST_ERR;
            end else begin
              remaining <= full_count;
              state     <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (word_valid) state <= ST_WRITE;
        end
        ST_WRITE: begin
          mem_addr     <= mem_addr + ADDR_W'(1);
          words_loaded <= words_loaded + 16'd1;
          remaining    <= remaining - 16'd1;
          state        <= (remaining == 16'd1) ? ST_DONE : ST_DATA;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected BRAM writes are queued as bytes are
// sent and popped by a write monitor; status outputs are checked after each load.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        mem_ena;
  logic [3:0]  mem_wea;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;
  state_t      dbg_state;

  logic [63:0] exp_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          wr_count = 0;

  imem_loader #(.ADDR_W(32), .DEPTH(1024), .BASE_ADDR(0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .mem_ena      (mem_ena),
    .mem_wea      (mem_wea),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded),
    .dbg_state    (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every BRAM strobe must match the next queued write.
  always @(negedge clk) begin
    if (rst_n && mem_ena) begin
      logic [63:0] e;
      wr_count++;
      if (exp_q.size() == 0) begin
        e = 64'hDEAD_DEAD_DEAD_DEAD;
      end else begin
        e = exp_q.pop_front();
      end
      check("write_addr_data", {mem_addr, mem_din}, e);
      check("write_wea", {60'd0, mem_wea}, 64'hF);
      check("write_s_ready_low", {63'd0, s_ready}, 64'd0);
    end
  end

  // Driver tasks; all called and returning on a falling edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int cnt;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    cnt = 0;
    while (!s_ready && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    if (!s_ready) check("send_byte_timeout", 64'd0, 64'd1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] addr, input logic [31:0] data, input bit gaps);
    exp_q.push_back({addr, data});
    for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8], gaps);
  endtask

  task automatic send_len(input logic [15:0] n);
    send_byte(n[15:8], 1'b0);
    send_byte(n[7:0], 1'b0);
  endtask

  task automatic wait_end();
    int cnt;
    cnt = 0;
    while (!done && !err && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (!done && !err) check("wait_end_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_s_ready"}, {63'd0, s_ready}, 64'd0);
    check({tag, "_mem_ena"}, {63'd0, mem_ena}, 64'd0);
    check({tag, "_mem_wea"}, {60'd0, mem_wea}, 64'd0);
    check({tag, "_mem_addr"}, {32'd0, mem_addr}, 64'd0);
    check({tag, "_mem_din"}, {32'd0, mem_din}, 64'd0);
    check({tag, "_status"}, {61'd0, busy, done, err}, 64'd0);
    check({tag, "_words"}, {48'd0, words_loaded}, 64'd0);
    check({tag, "_state"}, {61'd0, dbg_state}, {61'd0, ST_IDLE});
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    @(negedge clk);
    apply_reset();
    check_reset_values("reset");

    // N=2 basic load.
    wr_count = 0;
    pulse_start();
    check("busy_after_start", {62'd0, busy, s_ready}, 64'h3);
    send_len(16'd2);
    send_word(32'd0, 32'h0010_0013, 1'b0);
    send_word(32'd1, 32'h0020_0093, 1'b0);
    wait_end();
    check("n2_status", {61'd0, busy, done, err}, 64'h2);
    check("n2_words", {48'd0, words_loaded}, 64'd2);
    check("n2_writes", 64'(wr_count), 64'd2);
    check("n2_queue_empty", 64'(exp_q.size()), 64'd0);

    // N=0: straight to DONE, no writes.
    wr_count = 0;
    pulse_start();
    check("reload_done_drops", {62'd0, done, busy}, 64'h1);
    send_len(16'd0);
    check("n0_done", {61'd0, busy, done, err}, 64'h2);
    check("n0_words", {48'd0, words_loaded}, 64'd0);
    check("n0_writes", 64'(wr_count), 64'd0);

    // N=1025: over DEPTH -> ERR, then recover with N=1.
    wr_count = 0;
    pulse_start();
    send_len(16'd1025);
    check("err_status", {61'd0, busy, done, err}, 64'h1);
    repeat (3) @(negedge clk);
    check("err_sticky_no_ready", {62'd0, err, s_ready}, 64'h2);
    check("err_writes", 64'(wr_count), 64'd0);
    pulse_start();
    check("err_cleared", {62'd0, err, busy}, 64'h1);
    send_len(16'd1);
    send_word(32'd0, 32'hCAFE_0001, 1'b0);
    wait_end();
    check("err_recover_status", {61'd0, busy, done, err}, 64'h2);
    check("err_recover_writes", 64'(wr_count), 64'd1);

    // N=1024 is exactly DEPTH: accepted, not an error.
    pulse_start();
    send_len(16'd1024);
    check("depth_edge_busy", {62'd0, busy, err}, 64'h2);
    apply_reset();

    // N=3 with random valid gaps.
    wr_count = 0;
    pulse_start();
    send_len(16'd3);
    send_word(32'd0, 32'h1234_5678, 1'b1);
    send_word(32'd1, 32'h9ABC_DEF0, 1'b1);
    send_word(32'd2, 32'h0F1E_2D3C, 1'b1);
    wait_end();
    check("gaps_done", {61'd0, busy, done, err}, 64'h2);
    check("gaps_words", {48'd0, words_loaded}, 64'd3);
    check("gaps_writes", 64'(wr_count), 64'd3);

    // Asynchronous reset mid-load after the 2nd data byte.
    pulse_start();
    send_len(16'd1);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wr_count = 0;
    pulse_start();
    send_len(16'd1);
    send_word(32'd0, 32'h5555_AAAA, 1'b0);
    wait_end();
    check("post_reset_writes", 64'(wr_count), 64'd1);
    check("post_reset_words", {48'd0, words_loaded}, 64'd1);

    // start during DATA is ignored; second start in DONE restarts at BASE_ADDR.
    wr_count = 0;
    pulse_start();
    send_len(16'd2);
    send_byte(8'h01, 1'b0);
    exp_q.push_back({32'd0, 32'h0403_0201});
    pulse_start();
    check("start_in_data_ignored", {61'd0, dbg_state}, {61'd0, ST_DATA});
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b0);
    send_word(32'd1, 32'h0807_0605, 1'b0);
    wait_end();
    check("ignored_start_words", {48'd0, words_loaded}, 64'd2);
    check("ignored_start_writes", 64'(wr_count), 64'd2);
    pulse_start();
    check("restart_addr", {32'd0, mem_addr}, 64'd0);
    check("restart_words_clear", {48'd0, words_loaded}, 64'd0);
    send_len(16'd1);
    send_word(32'd0, 32'h7777_0000, 1'b0);
    wait_end();
    check("restart_done", {61'd0, busy, done, err}, 64'h2);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader for the instruction memory: accepts a byte stream (length header + instruction words), assembles 32-bit words and drives the write side of the instruction-memory BRAM port (ena/wea/addra/dina) that the fetch path only reads. Holds the processor out of run until the image is fully written. Sits between the host/serial byte source and the instruction-memory block; the fetch path's enable is gated by `done`.

## Interface

Parameters:
- `ADDR_W`, 32, width of BRAM word address (matches instruction-memory `addra`)
- `DEPTH`, 1024, maximum number of words the instruction memory holds
- `BASE_ADDR`, 0, word address of first instruction written

Ports:
- `clk`  in  1  system clock; all logic rising-edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle pulse; begins a load (honoured in IDLE, DONE, ERR only)
- `s_valid`  in  1  byte-stream valid
- `s_data`  in  8  byte-stream data
- `s_ready`  out  1  loader accepts byte this cycle when `s_valid && s_ready`
- `mem_ena`  out  1  BRAM port enable
- `mem_wea`  out  4  BRAM byte write enables
- `mem_addr`  out  ADDR_W  BRAM word address
- `mem_din`  out  32  BRAM write data
- `busy`  out  1  load in progress
- `done`  out  1  image loaded; gates processor run
- `err`  out  1  header word count exceeds `DEPTH`
- `words_loaded`  out  16  words written in current/last load

## Operation

- Stream format: 2-byte word count N, big-endian (high byte first); then N words, each 4 bytes little-endian (byte 0 = instr[7:0]).
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR.
- IDLE: `s_ready`=0. `start` -> LEN_HI; clear `words_loaded`, `mem_addr`<=BASE_ADDR.
- LEN_HI: `s_ready`=1; accepted byte -> count[15:8]; -> LEN_LO.
- LEN_LO: `s_ready`=1; accepted byte -> count[7:0]. Full count ==0 -> DONE; >DEPTH -> ERR; else -> DATA, byte_idx=0.
- DATA: `s_ready`=1; accepted byte placed at lane byte_idx of word register; byte_idx++ (2-bit wrap). Fourth byte -> WRITE.
- WRITE: `s_ready`=0; `mem_ena`=1, `mem_wea`=4'hF, `mem_din`=assembled word, `mem_addr`=current address for exactly one cycle. Next cycle: address++, `words_loaded`++, remaining--. Remaining reaches 0 -> DONE, else -> DATA.
- DONE: `done`=1 sticky; `busy`=0. `start` -> LEN_HI (reload; `done` drops the cycle after `start`).
- ERR: `err`=1 sticky, no writes issued. `start` -> LEN_HI, clears `err`.
- `busy`=1 in LEN_HI, LEN_LO, DATA, WRITE. `start` while busy ignored.
- `mem_wea`=0 and `mem_ena`=0 outside WRITE; loader never reads memory.
- Bytes with `s_valid`=0 or while `s_ready`=0 are not consumed; upstream must hold data.

## Timing

- Reset values: `s_ready`=0, `mem_ena`=0, `mem_wea`=0, `mem_addr`=BASE_ADDR, `mem_din`=0, `busy`=0, `done`=0, `err`=0, `words_loaded`=0; state IDLE.
- All outputs registered or decoded from registered state; no combinational path `s_valid`->`s_ready`.
- Write strobe appears the cycle after the 4th byte handshake; peak rate 1 word / 5 cycles.
- `done` rises the cycle after the last WRITE cycle (or after LEN_LO handshake when N=0).
- Address arithmetic ADDR_W-bit, no wrap checking beyond the DEPTH header check.
- Reset mid-load: immediate return to IDLE; partial image left in memory; `done`=0.

## Structure

- Shared package `imem_loader_pkg`: state enum, `LEN_BYTES`=2, `WORD_BYTES`=4, `WE_ALL`=4'hF.
- One sub-module natural: `byte_to_word` (2-bit lane counter + 32-bit assembly register, `word_valid` pulse on 4th byte). FSM, counters and BRAM drive stay in top.

## Test plan

- N=2, bytes 00 02 | 13 00 10 00 | 93 00 20 00 -> writes 0x00100013 @0, 0x00200093 @1; `done`=1, `words_loaded`=2, exactly 2 `mem_ena` pulses.
- N=0 (00 00) -> DONE directly, no `mem_ena` pulse, `words_loaded`=0.
- N=1025 with DEPTH=1024 (04 01) -> ERR, `err`=1, no writes; `start` then valid N=1 load -> `err`=0, `done`=1.
- Random `s_valid` gaps during N=3 load -> identical memory contents and addresses 0..2; `s_ready`=0 in every WRITE cycle.
- `rst_n` low after 2nd data byte -> all outputs at reset values asynchronously; fresh `start` + N=1 load writes @BASE_ADDR.
- `start` pulsed during DATA -> ignored; load completes normally; second `start` in DONE restarts at BASE_ADDR.
